// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//   Shares one single-port, fixed-latency memory between the instruction-fetch
//   port (read only) and the load/store port of the core. Requests are granted
//   combinationally while idle. A tie goes to the port that did not win last
//   time. Each access is then sequenced through a latency counter until its
//   response strobe is issued.
//
// Parameters
//   AW       address width
//   DW       data width
//   MEM_LAT  cycles from m_en to m_rdata valid (legal range 1..15)
//
// Ports
//   clk, rst                  clock; asynchronous active-low reset
//   i_req/i_addr              fetch request and address
//   i_gnt/i_rvalid/i_rdata    fetch accept strobe, data-valid strobe, data
//   d_req/d_we/d_addr/d_wdata data request, store enable, address, store data
//   d_gnt/d_rvalid/d_rdata    data accept strobe, load-valid/store-ack, data
//   m_en/m_we/m_addr/m_wdata  memory strobe, write, address, write data
//   m_rdata                   memory read data, MEM_LAT cycles after m_en
//   busy                      a transaction is in flight
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int MEM_LAT = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] i_rdata,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    output logic [DW-1:0] d_rdata,
    output logic          m_en,
    output logic          m_we,
    output logic [AW-1:0] m_addr,
    output logic [DW-1:0] m_wdata,
    input  logic [DW-1:0] m_rdata,
    output logic          busy
);

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } state_t;

    localparam logic [3:0] LAT = 4'(MEM_LAT);

    state_t     r_state;
    logic [3:0] r_cnt;
    logic       r_owner;       // 0 = instruction port, 1 = data port
    logic       r_last_owner;  // winner of the previous grant, for tie-breaks
    logic       r_is_store;    // in-flight data access is a store (ack carries no data)

    logic w_pick_d;
    logic w_grant;
    logic w_done;

    // Data wins when it is the only requester, or on a tie when the previous
    // grant went to the instruction port.
    assign w_pick_d = d_req & (~i_req | ~r_last_owner);

    // The request inputs reach the grant path combinationally, so the grant is
    // qualified with rst to keep every output at 0 while reset is held.
    assign w_grant  = rst & (r_state == ST_IDLE) & (i_req | d_req);
    assign w_done   = (r_state == ST_WAIT) & (r_cnt == 4'd1);

    assign i_gnt    = w_grant & ~w_pick_d;
    assign d_gnt    = w_grant & w_pick_d;
    assign m_en     = w_grant;
    assign m_we     = d_gnt & d_we;
    assign m_addr   = w_grant ? (w_pick_d ? d_addr : i_addr) : '0;
    assign m_wdata  = d_gnt ? d_wdata : '0;

    assign busy     = (r_state == ST_WAIT);
    assign i_rvalid = w_done & ~r_owner;
    assign d_rvalid = w_done & r_owner;
    assign i_rdata  = i_rvalid ? m_rdata : '0;
    assign d_rdata  = (d_rvalid & ~r_is_store) ? m_rdata : '0;

    // NOTE: state uses non-blocking assignments so every register samples the
    // pre-edge values; blocking here would let later lines see updated state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_cnt        <= 4'd0;
            r_owner      <= 1'b0;
            r_last_owner <= 1'b0;
            r_is_store   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant) begin
                        r_state      <= ST_WAIT;
                        r_cnt        <= LAT;
                        r_owner      <= w_pick_d;
                        r_last_owner <= w_pick_d;
                        r_is_store   <= w_pick_d & d_we;
                    end
                end
                ST_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    if (r_cnt == 4'd1) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
module tb_mem_arbiter;

    localparam int LAT_A = 2;
    localparam int LAT_B = 1;

    typedef struct packed {
        logic        rst_n;
        logic        i_req;
        logic [31:0] i_addr;
        logic        d_req;
        logic        d_we;
        logic [31:0] d_addr;
        logic [31:0] d_wdata;
    } in_t;

    typedef struct packed {
        logic        i_gnt;
        logic        d_gnt;
        logic        m_en;
        logic        m_we;
        logic [31:0] m_addr;
        logic [31:0] m_wdata;
        logic        busy;
        logic        i_rv;
        logic        d_rv;
        logic [31:0] i_rd;
        logic [31:0] d_rd;
    } out_t;

    typedef struct {
        in_t  i;
        out_t o;
    } vec_t;

    logic clk;
    int   n_vec = 0;
    int   n_bad = 0;

    // DUT A (MEM_LAT=2) signals
    logic        a_rst, a_i_req, a_i_gnt, a_i_rvalid, a_d_req, a_d_we, a_d_gnt, a_d_rvalid;
    logic        a_m_en, a_m_we, a_busy;
    logic [31:0] a_i_addr, a_i_rdata, a_d_addr, a_d_wdata, a_d_rdata;
    logic [31:0] a_m_addr, a_m_wdata, a_m_rdata;

    // DUT B (MEM_LAT=1) signals
    logic        b_rst, b_i_req, b_i_gnt, b_i_rvalid, b_d_req, b_d_we, b_d_gnt, b_d_rvalid;
    logic        b_m_en, b_m_we, b_busy;
    logic [31:0] b_i_addr, b_i_rdata, b_d_addr, b_d_wdata, b_d_rdata;
    logic [31:0] b_m_addr, b_m_wdata, b_m_rdata;

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT_A)) u_dut_a (
        .clk(clk), .rst(a_rst),
        .i_req(a_i_req), .i_addr(a_i_addr), .i_gnt(a_i_gnt), .i_rvalid(a_i_rvalid), .i_rdata(a_i_rdata),
        .d_req(a_d_req), .d_we(a_d_we), .d_addr(a_d_addr), .d_wdata(a_d_wdata),
        .d_gnt(a_d_gnt), .d_rvalid(a_d_rvalid), .d_rdata(a_d_rdata),
        .m_en(a_m_en), .m_we(a_m_we), .m_addr(a_m_addr), .m_wdata(a_m_wdata), .m_rdata(a_m_rdata),
        .busy(a_busy)
    );

    mem_arbiter #(.AW(32), .DW(32), .MEM_LAT(LAT_B)) u_dut_b (
        .clk(clk), .rst(b_rst),
        .i_req(b_i_req), .i_addr(b_i_addr), .i_gnt(b_i_gnt), .i_rvalid(b_i_rvalid), .i_rdata(b_i_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(b_d_wdata),
        .d_gnt(b_d_gnt), .d_rvalid(b_d_rvalid), .d_rdata(b_d_rdata),
        .m_en(b_m_en), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata), .m_rdata(b_m_rdata),
        .busy(b_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Power-on contents of every memory word (unwritten locations).
    function automatic logic [31:0] init_val(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    // Environment memories: fixed-latency read pipeline, garbage when idle.
    logic [31:0] ram_a [512];
    bit          wr_a  [512];
    logic [31:0] pipe_a [2];
    logic [31:0] ram_b [512];
    bit          wr_b  [512];
    logic [31:0] pipe_b;

    always @(posedge clk) begin
        if (a_m_en) begin
            pipe_a[0] <= wr_a[a_m_addr[10:2]] ? ram_a[a_m_addr[10:2]] : init_val(a_m_addr);
            if (a_m_we) begin
                ram_a[a_m_addr[10:2]] <= a_m_wdata;
                wr_a[a_m_addr[10:2]]  <= 1'b1;
            end
        end else begin
            pipe_a[0] <= $urandom;
        end
        pipe_a[1] <= pipe_a[0];
        if (b_m_en) begin
            pipe_b <= wr_b[b_m_addr[10:2]] ? ram_b[b_m_addr[10:2]] : init_val(b_m_addr);
            if (b_m_we) begin
                ram_b[b_m_addr[10:2]] <= b_m_wdata;
                wr_b[b_m_addr[10:2]]  <= 1'b1;
            end
        end else begin
            pipe_b <= $urandom;
        end
    end
    assign a_m_rdata = pipe_a[LAT_A-1];
    assign b_m_rdata = pipe_b;

    // ---- vector helpers ----
    function automatic in_t iv(input logic rn, input logic ir, input logic [31:0] ia,
                               input logic dr, input logic dw, input logic [31:0] da,
                               input logic [31:0] dd);
        in_t v;
        v.rst_n = rn; v.i_req = ir; v.i_addr = ia;
        v.d_req = dr; v.d_we = dw; v.d_addr = da; v.d_wdata = dd;
        return v;
    endfunction

    function automatic in_t iv_idle();
        return iv(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    endfunction

    function automatic out_t o0();
        out_t o = '0;
        return o;
    endfunction

    function automatic out_t og(input bit d, input logic [31:0] a, input logic we, input logic [31:0] wd);
        out_t o = '0;
        o.i_gnt = !d; o.d_gnt = d; o.m_en = 1'b1; o.m_we = we; o.m_addr = a; o.m_wdata = wd;
        return o;
    endfunction

    function automatic out_t ow();
        out_t o = '0;
        o.busy = 1'b1;
        return o;
    endfunction

    function automatic out_t orsp(input bit d, input logic [31:0] data);
        out_t o = '0;
        o.busy = 1'b1;
        if (d) begin o.d_rv = 1'b1; o.d_rd = data; end
        else   begin o.i_rv = 1'b1; o.i_rd = data; end
        return o;
    endfunction

    function automatic string fmt(input out_t o);
        return $sformatf("gnt(i,d)=%b%b m_en=%b m_we=%b m_addr=%h m_wdata=%h busy=%b rvalid(i,d)=%b%b i_rdata=%h d_rdata=%h",
                         o.i_gnt, o.d_gnt, o.m_en, o.m_we, o.m_addr, o.m_wdata, o.busy,
                         o.i_rv, o.d_rv, o.i_rd, o.d_rd);
    endfunction

    function automatic out_t out_of(input bit sel);
        out_t o;
        if (!sel) begin
            o.i_gnt = a_i_gnt; o.d_gnt = a_d_gnt; o.m_en = a_m_en; o.m_we = a_m_we;
            o.m_addr = a_m_addr; o.m_wdata = a_m_wdata; o.busy = a_busy;
            o.i_rv = a_i_rvalid; o.d_rv = a_d_rvalid; o.i_rd = a_i_rdata; o.d_rd = a_d_rdata;
        end else begin
            o.i_gnt = b_i_gnt; o.d_gnt = b_d_gnt; o.m_en = b_m_en; o.m_we = b_m_we;
            o.m_addr = b_m_addr; o.m_wdata = b_m_wdata; o.busy = b_busy;
            o.i_rv = b_i_rvalid; o.d_rv = b_d_rvalid; o.i_rd = b_i_rdata; o.d_rd = b_d_rdata;
        end
        return o;
    endfunction

    // One clock cycle: drive inputs after the falling edge, compare before the rising edge.
    task automatic check(input bit sel, input in_t v, input out_t e, input string name);
        out_t act;
        @(negedge clk);
        if (!sel) begin
            a_rst = v.rst_n; a_i_req = v.i_req; a_i_addr = v.i_addr;
            a_d_req = v.d_req; a_d_we = v.d_we; a_d_addr = v.d_addr; a_d_wdata = v.d_wdata;
        end else begin
            b_rst = v.rst_n; b_i_req = v.i_req; b_i_addr = v.i_addr;
            b_d_req = v.d_req; b_d_we = v.d_we; b_d_addr = v.d_addr; b_d_wdata = v.d_wdata;
        end
        #2;
        act = out_of(sel);
        n_vec++;
        if (act !== e) begin
            n_bad++;
            $display("FAIL %s: got %s | want %s", name, fmt(act), fmt(e));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---- main test ----
    vec_t        tab [25];
    in_t         v;
    out_t        e;
    logic [31:0] mm [logic [31:0]];
    int          free_at, resp_at;
    bit          resp_d, last_d, win_d, gi, gd;
    logic [31:0] resp_data, addr, i_a, d_a, d_wd;
    bit          i_pend, d_pend, d_w;
    logic        we;

    initial begin
        a_rst = 1'b1; a_i_req = 0; a_i_addr = 0; a_d_req = 0; a_d_we = 0; a_d_addr = 0; a_d_wdata = 0;
        b_rst = 1'b1; b_i_req = 0; b_i_addr = 0; b_d_req = 0; b_d_we = 0; b_d_addr = 0; b_d_wdata = 0;
        #1;
        a_rst = 1'b0;
        b_rst = 1'b0;
        repeat (2) @(posedge clk);

        // Directed table: reset, single fetch, store/load, alternating ties.
        tab[0]  = '{iv(0, 1, 32'h40, 1, 0, 32'h100, 32'h0), o0()};
        tab[1]  = '{iv(1, 1, 32'h40, 0, 0, 32'h0, 32'h0), og(0, 32'h40, 0, 32'h0)};
        tab[2]  = '{iv_idle(), ow()};
        tab[3]  = '{iv_idle(), orsp(0, init_val(32'h40))};
        tab[4]  = '{iv_idle(), o0()};
        tab[5]  = '{iv(1, 0, 32'h0, 1, 1, 32'h100, 32'hDEADBEEF), og(1, 32'h100, 1, 32'hDEADBEEF)};
        tab[6]  = '{iv_idle(), ow()};
        tab[7]  = '{iv_idle(), orsp(1, 32'h0)};
        tab[8]  = '{iv(1, 0, 32'h0, 1, 0, 32'h100, 32'h0), og(1, 32'h100, 0, 32'h0)};
        tab[9]  = '{iv_idle(), ow()};
        tab[10] = '{iv_idle(), orsp(1, 32'hDEADBEEF)};
        tab[11] = '{iv(0, 1, 32'h80, 1, 0, 32'h200, 32'h12345678), o0()};
        tab[12] = '{iv(1, 1, 32'h80, 1, 0, 32'h200, 32'h12345678), og(1, 32'h200, 0, 32'h12345678)};
        tab[13] = '{tab[12].i, ow()};
        tab[14] = '{tab[12].i, orsp(1, init_val(32'h200))};
        tab[15] = '{tab[12].i, og(0, 32'h80, 0, 32'h0)};
        tab[16] = '{tab[12].i, ow()};
        tab[17] = '{tab[12].i, orsp(0, init_val(32'h80))};
        tab[18] = '{tab[12].i, og(1, 32'h200, 0, 32'h12345678)};
        tab[19] = '{tab[12].i, ow()};
        tab[20] = '{tab[12].i, orsp(1, init_val(32'h200))};
        tab[21] = '{tab[12].i, og(0, 32'h80, 0, 32'h0)};
        tab[22] = '{tab[12].i, ow()};
        tab[23] = '{iv_idle(), orsp(0, init_val(32'h80))};
        tab[24] = '{iv_idle(), o0()};
        for (int k = 0; k < 25; k++) begin
            check(0, tab[k].i, tab[k].o, $sformatf("table[%0d]", k));
        end

        // Fetch request rising while a load is in flight waits for IDLE.
        check(0, iv(1, 0, 32'h0, 1, 0, 32'h48, 32'h0), og(1, 32'h48, 0, 32'h0), "wait_req_c0");
        check(0, iv(1, 1, 32'h4C, 0, 0, 32'h0, 32'h0), ow(), "wait_req_c1");
        check(0, iv(1, 1, 32'h4C, 0, 0, 32'h0, 32'h0), orsp(1, init_val(32'h48)), "wait_req_c2");
        check(0, iv(1, 1, 32'h4C, 0, 0, 32'h0, 32'h0), og(0, 32'h4C, 0, 32'h0), "wait_req_c3");
        check(0, iv_idle(), ow(), "wait_req_c4");
        check(0, iv_idle(), orsp(0, init_val(32'h4C)), "wait_req_c5");

        // Reset in the first WAIT cycle aborts the access without a response.
        check(0, iv(1, 0, 32'h0, 1, 0, 32'h50, 32'h0), og(1, 32'h50, 0, 32'h0), "rst_mid_c0");
        check(0, iv(0, 0, 32'h0, 1, 0, 32'h50, 32'h0), o0(), "rst_mid_c1");
        check(0, iv(1, 0, 32'h0, 1, 0, 32'h54, 32'h0), og(1, 32'h54, 0, 32'h0), "rst_mid_c2");
        check(0, iv_idle(), ow(), "rst_mid_c3");
        check(0, iv_idle(), orsp(1, init_val(32'h54)), "rst_mid_c4");
        check(0, iv_idle(), o0(), "rst_mid_c5");

        // MEM_LAT=1: back-to-back fetches every other cycle.
        check(1, iv(0, 1, 32'h0, 0, 0, 32'h0, 32'h0), o0(), "lat1_rst");
        check(1, iv(1, 1, 32'h0, 0, 0, 32'h0, 32'h0), og(0, 32'h0, 0, 32'h0), "lat1_c0");
        check(1, iv(1, 1, 32'h4, 0, 0, 32'h0, 32'h0), orsp(0, init_val(32'h0)), "lat1_c1");
        check(1, iv(1, 1, 32'h4, 0, 0, 32'h0, 32'h0), og(0, 32'h4, 0, 32'h0), "lat1_c2");
        check(1, iv(1, 1, 32'h8, 0, 0, 32'h0, 32'h0), orsp(0, init_val(32'h4)), "lat1_c3");
        check(1, iv(1, 1, 32'h8, 0, 0, 32'h0, 32'h0), og(0, 32'h8, 0, 32'h0), "lat1_c4");
        check(1, iv_idle(), orsp(0, init_val(32'h8)), "lat1_c5");
        check(1, iv_idle(), o0(), "lat1_c6");

        // Randomized traffic on DUT A against a transaction-level model:
        // the memory is free from free_at on, a grant's response is due LAT_A
        // cycles later, ties go to the port that did not win last.
        check(0, iv(0, 1, 32'h0, 1, 0, 32'h0, 32'h0), o0(), "rand_rst");
        free_at = 0; resp_at = -1; resp_d = 0; resp_data = 0; last_d = 0;
        i_pend = 0; d_pend = 0; i_a = 0; d_a = 0; d_wd = 0; d_w = 0;
        for (int c = 0; c < 600; c++) begin
            if (!i_pend && ($urandom % 2 == 0)) begin
                i_pend = 1; i_a = 32'h400 | (32'($urandom_range(0, 255)) << 2);
            end else if (i_pend && ($urandom % 16 == 0)) begin
                i_pend = 0;
            end
            if (!d_pend && ($urandom % 2 == 0)) begin
                d_pend = 1; d_a = 32'h400 | (32'($urandom_range(0, 255)) << 2);
                d_w = ($urandom % 3 == 0); d_wd = $urandom;
            end else if (d_pend && ($urandom % 16 == 0)) begin
                d_pend = 0;
            end
            v = iv(1, i_pend, i_pend ? i_a : $urandom, d_pend,
                   d_pend ? d_w : 1'($urandom), d_pend ? d_a : $urandom, d_pend ? d_wd : $urandom);

            e = '0; gi = 0; gd = 0;
            if (c < free_at) e.busy = 1'b1;
            if (c == resp_at) begin
                if (resp_d) begin e.d_rv = 1'b1; e.d_rd = resp_data; end
                else        begin e.i_rv = 1'b1; e.i_rd = resp_data; end
            end
            if (c >= free_at && (v.i_req || v.d_req)) begin
                win_d = (v.i_req && v.d_req) ? !last_d : v.d_req;
                addr  = win_d ? v.d_addr : v.i_addr;
                we    = win_d && v.d_we;
                e = og(win_d, addr, we, win_d ? v.d_wdata : 32'h0);
                resp_data = we ? 32'h0 : (mm.exists(addr) ? mm[addr] : init_val(addr));
                if (we) mm[addr] = v.d_wdata;
                resp_at = c + LAT_A;
                free_at = c + LAT_A + 1;
                resp_d  = win_d;
                last_d  = win_d;
                gi = !win_d;
                gd = win_d;
            end
            check(0, v, e, $sformatf("rand[%0d]", c));
            if (gi) i_pend = 0;
            if (gd) d_pend = 0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one single-port, fixed-latency memory between the instruction-fetch port and the load/store port of the MIPS core.
- Sits between the core and a unified instruction/data RAM, for configurations where separate instruction and data memories are not used.
- Arbitrates with a round-robin tie-break and sequences each access through a latency counter.
- Returns responses on per-requester valid strobes.

Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 2, cycles from m_en to m_rdata valid; legal range 1..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- i_req  in  1  fetch request, read only.
- i_addr  in  AW  fetch address.
- i_gnt  out  1  fetch request accepted this cycle.
- i_rvalid  out  1  fetch data valid this cycle.
- i_rdata  out  DW  fetch data.
- d_req  in  1  data request.
- d_we  in  1  data write enable (1 = store).
- d_addr  in  AW  data address.
- d_wdata  in  DW  store data.
- d_gnt  out  1  data request accepted this cycle.
- d_rvalid  out  1  load data valid, or store acknowledged, this cycle.
- d_rdata  out  DW  load data.
- m_en  out  1  memory access strobe.
- m_we  out  1  memory write.
- m_addr  out  AW  memory address.
- m_wdata  out  DW  memory write data.
- m_rdata  in  DW  memory read data, valid MEM_LAT cycles after m_en.
- busy  out  1  transaction in flight (state WAIT).

Behaviour:
- State machine: IDLE, WAIT.
- Registers: state; cnt (4 bits); owner (0 = instr, 1 = data); last_owner.
- Reset (rst=0, asynchronous):
  - state=IDLE, cnt=0, owner=0, last_owner=0.
  - All outputs forced to 0 while rst=0, regardless of the request inputs.
- IDLE, no request: all outputs 0.
- IDLE, request present: grant is combinational in the same cycle.
  - Only i_req: grant instr.
  - Only d_req: grant data.
  - Both: grant the port that is not last_owner. After reset, data wins the first tie.
  - Granted port: x_gnt=1 and m_en=1 for exactly this one cycle.
  - Memory mux: m_addr = granted address; m_we = d_we & data-granted; m_wdata = d_wdata when data is granted, else 0.
  - Next edge: state=WAIT, cnt=MEM_LAT, owner=granted port, last_owner=granted port.
- WAIT:
  - busy=1; no grants; m_en=0; m_addr, m_we, m_wdata driven 0. The memory captures the request at the m_en edge.
  - cnt decrements each cycle.
  - When cnt==1: the owner's x_rvalid=1 for one cycle, and x_rdata=m_rdata for reads (0 for a store ack). Next edge: state=IDLE.
- Timing:
  - Request-to-response latency is MEM_LAT cycles after the grant cycle.
  - Peak throughput is one access per MEM_LAT+1 cycles.
  - The non-owner's rvalid and rdata stay 0.
- Requester rules:
  - Hold req, addr, we and wdata stable until gnt.
  - req may drop in the cycle after gnt; that is not a new request.
  - req dropped before grant: no transaction is issued.
  - req held high after gnt is treated as a new request on return to IDLE.
- Starvation: with both ports requesting continuously, grants alternate I, D, I, D… (after reset D first); neither port waits more than one transaction.
- Reset mid-WAIT: abort immediately; no rvalid for the in-flight access; any late m_rdata is ignored.
- A store that completes before a subsequent load to the same address must be visible to that load. The memory is single-port and serialized, so no forwarding is required.

Test Plan:
- Single fetch, MEM_LAT=2: i_req=1, i_addr=0x40 at cycle 0 -> i_gnt=1, m_en=1, m_addr=0x40 at cycle 0; busy=1 at cycles 1-2; i_rvalid=1 with i_rdata=mem[0x40] at cycle 2; IDLE at cycle 3.
- Store then load: d_we=1, d_addr=0x100, d_wdata=0xDEADBEEF -> m_we=1 at grant, d_rvalid=1 with d_rdata=0 two cycles later; then a load from 0x100 -> d_rdata=0xDEADBEEF.
- Simultaneous requests held high for 4 transactions after reset -> grant order D, I, D, I; each rvalid is on the correct port only; the non-owner's rdata stays 0.
- Request arriving during WAIT: i_req rises at cycle 1 of a data access -> no i_gnt until the cycle after d_rvalid; then i_gnt=1.
- Reset mid-transaction: rst low at cycle 1 of WAIT -> all outputs 0 immediately, no rvalid ever issued for that access; after release, d_req alone is granted the same cycle.
- MEM_LAT=1 build: back-to-back fetches at addresses 0, 4, 8 -> grants at cycles 0, 2, 4; i_rvalid at cycles 1, 3, 5.
